datamem_arbiter: RTL

- Shares the single data memory port between two requesters: requester 0 is the CPU memory stage, requester 1 is the loader/debug port.
- Accesses are granted one at a time with round-robin fairness, and the memory command is registered.
- Requester 0 gets a stall output so the pipeline control can freeze upstream stages until its access completes.
- Misaligned accesses are rejected without touching memory.

---
 rtl/datamem_arbiter_if.sv | 19 +
 rtl/datamem_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/datamem_arbiter_if.sv
// datamem_arbiter_if: requester handshakes and data-memory port of datamem_arbiter.
interface datamem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1, mem_addr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic [3:0] size0, size1, mem_size;
  logic done0, done1, err0, err1, stall0, mem_re, mem_we;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, size0, size1, mem_rdata,
    output done0, done1, err0, err1, rdata, stall0, mem_addr, mem_wdata, mem_size, mem_re, mem_we
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, size0, size1, mem_rdata,
    input  done0, done1, err0, err1, rdata, stall0, mem_addr, mem_wdata, mem_size, mem_re, mem_we
  );
endinterface

// File: rtl/datamem_arbiter.sv
// datamem_arbiter: round-robin sharing of the data memory port between the CPU (0) and loader (1).
// Define DATAMEM_ARB_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module datamem_arbiter #(
  parameter int ACCESS_CYCLES = 1,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic clk,
  input logic rst,
  datamem_arbiter_if.slave bus
`ifdef DATAMEM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] CYC_INIT = 4'(ACCESS_CYCLES - 1);
  state_t state_q, state_d;
  logic grant_q, grant_d, we_q, we_d, err_q, err_d;
  logic [3:0] cyc_q, cyc_d, size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] sel_size;
  logic any_req, both_req, win, bad, done0, done1;
  assign any_req = bus.req0 | bus.req1;
  assign both_req = bus.req0 & bus.req1;
  assign win = both_req ? ~grant_q : bus.req1;
  assign sel_addr = win ? bus.addr1 : bus.addr0;
  assign sel_size = win ? bus.size1 : bus.size0;
  // Legal sizes are powers of two, so alignment reduces to a mask on the low address bits.
  assign bad = !(sel_size inside {4'd1, 4'd2, 4'd4, 4'd8}) || |(sel_addr[3:0] & (sel_size - 4'd1));
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d = we_q;
    err_d = err_q;
    cyc_d = cyc_q;
    size_d = size_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (any_req) begin
        grant_d = win;
        we_d = win ? bus.we1 : bus.we0;
        addr_d = sel_addr;
        size_d = sel_size;
        wdata_d = win ? bus.wdata1 : bus.wdata0;
        cyc_d = CYC_INIT;
        err_d = bad;
        state_d = bad ? DONE : BUSY;
      end
      BUSY: if (cyc_q == 4'd0) begin
        state_d = DONE;
        rdata_d = we_q ? rdata_q : bus.mem_rdata;
      end else begin
        cyc_d = cyc_q - 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      we_q <= 1'b0;
      err_q <= 1'b0;
      cyc_q <= '0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q <= we_d;
      err_q <= err_d;
      cyc_q <= cyc_d;
      size_q <= size_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign done0 = state_q == DONE && !grant_q;
  assign done1 = state_q == DONE && grant_q;
  assign bus.done0 = done0;
  assign bus.done1 = done1;
  assign bus.err0 = done0 && err_q;
  assign bus.err1 = done1 && err_q;
  assign bus.rdata = rdata_q;
  assign bus.stall0 = bus.req0 & ~done0;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_size = size_q;
  assign bus.mem_re = state_q == BUSY && !we_q;
  assign bus.mem_we = state_q == BUSY && we_q && cyc_q == 4'd0;
`ifdef DATAMEM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  always_comb begin
    conflict_cnt_d = (state_q == IDLE && both_req && conflict_cnt_q != 16'hFFFF) ? conflict_cnt_q + 16'd1 : conflict_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) conflict_cnt_q <= '0;
    else conflict_cnt_q <= conflict_cnt_d;
  end
  assign conflict_cnt = conflict_cnt_q;
`endif
endmodule
